// File: rtl/fc_pkg.sv
// fc_pkg: shared FSM state, address-width helper and output saturation for fc_layer_stream.
package fc_pkg;

   typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Result fits in dw bits; callers keep only the low dw bits.
   function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc, input int shift, input int dw);
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      s  = acc >>> shift;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      return (s > hi) ? hi : (s < lo) ? lo : s;
   endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// fc_mac_lane: one signed multiply-accumulate lane, preloading the bias on the first term.
module fc_mac_lane #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_en,
   input  logic                     i_first,
   input  logic signed [DATA_W-1:0] i_bias,
   input  logic signed [DATA_W-1:0] i_act,
   input  logic signed [DATA_W-1:0] i_wt,
   output logic signed [ACC_W-1:0]  o_acc
);

   logic signed [ACC_W-1:0]    r_acc;
   logic signed [ACC_W-1:0]    w_base;
   logic signed [2*DATA_W-1:0] w_prod;

   always_comb begin
      w_base = i_first ? ACC_W'(i_bias) : r_acc;
      w_prod = (2*DATA_W)'(i_act) * (2*DATA_W)'(i_wt);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_acc <= '0;
      else if (i_en)
         r_acc <= w_base + ACC_W'(w_prod);
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/fc_layer_stream.sv
// fc_layer_stream: time-multiplexed FC layer, NUM_PE neurons per pass over a buffered input vector.
// Define FC_RELU_EN to clamp negative outputs to zero after saturation.
module fc_layer_stream
   import fc_pkg::*;
#(
   parameter int IN_DIM    = 64,
   parameter int OUT_DIM   = 16,
   parameter int NUM_PE    = 4,
   parameter int DATA_W    = 8,
   parameter int ACC_W     = 24,
   parameter int OUT_SHIFT = 0
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [DATA_W-1:0]                   in_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [DATA_W-1:0]                   out_data,
   output logic                                out_last,
   input  logic                                w_we,
   input  logic [addr_w(OUT_DIM*IN_DIM)-1:0]   w_addr,
   input  logic [DATA_W-1:0]                   w_data,
   input  logic                                b_we,
   input  logic [addr_w(OUT_DIM)-1:0]          b_addr,
   input  logic [DATA_W-1:0]                   b_data,
   output logic                                busy
);

   localparam int NG   = OUT_DIM / NUM_PE;
   localparam int WA_W = addr_w(OUT_DIM * IN_DIM);
   localparam int BA_W = addr_w(OUT_DIM);
   localparam int K_W  = addr_w(IN_DIM);
   localparam int G_W  = addr_w(NG);
   localparam int P_W  = addr_w(NUM_PE);

   state_t                    r_state;
   logic [K_W-1:0]            r_idx;
   logic [K_W-1:0]            r_k;
   logic [G_W-1:0]            r_g;
   logic [P_W-1:0]            r_p;
   logic                      r_in_ready;
   logic                      r_busy;
   logic                      r_out_valid;
   logic                      r_out_last;
   logic signed [DATA_W-1:0]  r_ibuf [IN_DIM];
   logic signed [DATA_W-1:0]  r_wram [OUT_DIM*IN_DIM];
   logic signed [DATA_W-1:0]  r_bram [OUT_DIM];
   logic signed [ACC_W-1:0]   w_acc  [NUM_PE];
   logic signed [ACC_W-1:0]   w_sel;
   logic [DATA_W-1:0]         w_sat;
   logic                      w_idx_end;
   logic                      w_k_end;
   logic                      w_g_end;
   logic                      w_p_end;

   always_comb begin
      w_idx_end = r_idx == K_W'(IN_DIM - 1);
      w_k_end   = r_k == K_W'(IN_DIM - 1);
      w_g_end   = r_g == G_W'(NG - 1);
      w_p_end   = r_p == P_W'(NUM_PE - 1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= LOAD;
         r_idx       <= '0;
         r_k         <= '0;
         r_g         <= '0;
         r_p         <= '0;
         r_in_ready  <= 1'b1;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else begin
         case (r_state)
            LOAD: if (in_valid) begin
               r_idx <= w_idx_end ? '0 : r_idx + 1'b1;
               if (w_idx_end) begin
                  r_g        <= '0;
                  r_k        <= '0;
                  r_state    <= COMPUTE;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            COMPUTE: begin
               r_k <= w_k_end ? '0 : r_k + 1'b1;
               if (w_k_end) begin
                  r_p         <= '0;
                  r_state     <= OUTPUT;
                  r_out_valid <= 1'b1;
                  r_out_last  <= w_g_end && (NUM_PE == 1);
               end
            end
            OUTPUT: if (out_ready) begin
               if (w_p_end) begin
                  r_p         <= '0;
                  r_g         <= w_g_end ? '0 : r_g + 1'b1;
                  r_state     <= w_g_end ? LOAD : COMPUTE;
                  r_in_ready  <= w_g_end;
                  r_busy      <= !w_g_end;
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
               end else begin
                  r_p        <= r_p + 1'b1;
                  r_out_last <= w_g_end && (32'(r_p) + 32'd2 == 32'(NUM_PE));
               end
            end
            default: r_state <= LOAD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r_in_ready && in_valid)
         r_ibuf[r_idx] <= in_data;
   end

   // Coefficient RAMs are frozen while a vector is in flight.
   always_ff @(posedge clk) begin
      if (!r_busy && w_we && (32'(w_addr) < 32'(OUT_DIM * IN_DIM)))
         r_wram[w_addr] <= w_data;
      if (!r_busy && b_we && (32'(b_addr) < 32'(OUT_DIM)))
         r_bram[b_addr] <= b_data;
   end

   for (genvar p = 0; p < NUM_PE; p++) begin : g_lane
      logic [WA_W-1:0] w_wa;
      logic [BA_W-1:0] w_ba;
      assign w_ba = BA_W'(32'(r_g) * 32'(NUM_PE) + 32'(p));
      assign w_wa = WA_W'((32'(r_g) * 32'(NUM_PE) + 32'(p)) * 32'(IN_DIM) + 32'(r_k));
      fc_mac_lane #(
         .DATA_W (DATA_W),
         .ACC_W  (ACC_W)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_en    (r_state == COMPUTE),
         .i_first (r_k == '0),
         .i_bias  (r_bram[w_ba]),
         .i_act   (r_ibuf[r_k]),
         .i_wt    (r_wram[w_wa]),
         .o_acc   (w_acc[p])
      );
   end

   always_comb begin
      w_sel = w_acc[r_p];
      w_sat = DATA_W'(sat_shift(64'(w_sel), OUT_SHIFT, DATA_W));
   end

`ifdef FC_RELU_EN
   assign out_data = w_sat[DATA_W-1] ? '0 : w_sat;
`else
   assign out_data = w_sat;
`endif

   assign in_ready  = r_in_ready;
   assign busy      = r_busy;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;

endmodule

// File: tb/tb_fc_layer_stream.sv
// tb_fc_layer_stream: three shift variants driven in lockstep, checked against an arithmetic model.
module tb_fc_layer_stream;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic       w_we = 1'b0;
   logic       b_we = 1'b0;
   logic [7:0] in_data = '0;
   logic [7:0] w_data = '0;
   logic [7:0] b_data = '0;
   logic [3:0] w_addr = '0;
   logic [1:0] b_addr = '0;
   logic       ir [3];
   logic       ov [3];
   logic       ol [3];
   logic       bz [3];
   logic [7:0] od [3];
   int         total = 0;
   int         bad = 0;
   int         wm [16];
   int         bm [4];
   int         xv [4];
   int         sh [3] = '{0, 4, 1};

   always #5 clk = ~clk;

   for (genvar i = 0; i < 3; i++) begin : g_dut
      fc_layer_stream #(
         .IN_DIM(4), .OUT_DIM(4), .NUM_PE(2), .DATA_W(8), .ACC_W(24),
         .OUT_SHIFT(i == 0 ? 0 : i == 1 ? 4 : 1)
      ) u_dut (
         .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[i]), .in_data(in_data),
         .out_valid(ov[i]), .out_ready(out_ready), .out_data(od[i]), .out_last(ol[i]),
         .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
         .b_we(b_we), .b_addr(b_addr), .b_data(b_data), .busy(bz[i])
      );
   end

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int expect_out(input int n, input int s);
      int acc;
      acc = bm[n];
      for (int k = 0; k < 4; k++) acc += xv[k] * wm[n*4+k];
      acc = acc >>> s;
      if (acc > 127) acc = 127;
      if (acc < -128) acc = -128;
`ifdef FC_RELU_EN
      if (acc < 0) acc = 0;
`endif
      return acc;
   endfunction

   function automatic int rnd8();
      return int'($urandom_range(255)) - 128;
   endfunction

   task automatic program_mem();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         w_we = 1'b1; w_addr = 4'(i); w_data = 8'(wm[i]);
         b_we = (i < 4); b_addr = 2'(i); b_data = 8'(bm[i % 4]);
      end
      @(negedge clk);
      w_we = 1'b0; b_we = 1'b0;
   endtask

   task automatic send_vec(input bit gaps, input bit wr);
      int i = 0;
      int guard = 0;
      int a;
      while (i < 4 && guard < 100) begin
         @(negedge clk);
         guard++;
         w_we = 1'b0;
         if (wr && $urandom_range(1) == 1) begin
            a = int'($urandom_range(15));
            wm[a] = rnd8();
            w_we = 1'b1; w_addr = 4'(a); w_data = 8'(wm[a]);
         end
         if (gaps && $urandom_range(1) == 1)
            in_valid = 1'b0;
         else begin
            in_valid = 1'b1;
            in_data = 8'(xv[i]);
            if (ir[0]) i++;
         end
      end
      if (i < 4) check("send_timeout", i, 4);
      @(negedge clk);
      in_valid = 1'b0; w_we = 1'b0;
   endtask

   task automatic recv(input int stall, input bit rnd_ready);
      int lat = 1;
      int n = 0;
      int guard = 0;
      int hold = stall;
      while (!ov[0] && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 5);
      while (n < 4 && guard < 400) begin
         if (ov[0]) begin
            for (int i = 0; i < 3; i++)
               check($sformatf("data_sh%0d_n%0d", sh[i], n), int'($signed(od[i])), expect_out(n, sh[i]));
            check($sformatf("last_n%0d", n), int'(ol[0]), int'(n == 3));
            if (hold > 0) begin
               out_ready = 1'b0;
               hold--;
            end else
               out_ready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
            if (out_ready) n++;
         end else
            out_ready = 1'($urandom_range(1));
         @(negedge clk);
         guard++;
      end
      check("recv_count", n, 4);
      check("idle_valid", int'(ov[0]), 0);
      check("idle_ready", int'(ir[0]), 1);
      out_ready = 1'b0;
   endtask

   task automatic setup_basic(input int b0, input int b1, input int b2, input int b3);
      for (int i = 0; i < 16; i++) wm[i] = 1;
      bm = '{b0, b1, b2, b3};
      xv = '{1, 2, 3, 4};
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_in_ready", int'(ir[0]), 1);
      check("rst_out_valid", int'(ov[0]), 0);
      check("rst_out_last", int'(ol[0]), 0);
      check("rst_busy", int'(bz[0]), 0);
      for (int i = 0; i < 3; i++) check($sformatf("rst_data%0d", i), int'(od[i]), 0);
      rst_n = 1'b1;

      setup_basic(0, 0, 0, 0);
      program_mem();
      send_vec(1'b0, 1'b0);
      recv(0, 1'b0);

      for (int i = 0; i < 16; i++) wm[i] = (i < 4) ? 127 : (i < 8) ? -128 : 1;
      bm = '{0, 0, 0, 0};
      xv = '{127, 127, 127, 127};
      program_mem();
      send_vec(1'b0, 1'b0);
      recv(0, 1'b0);

      setup_basic(-3, 0, 5, 100);
      program_mem();
      send_vec(1'b0, 1'b0);
      recv(0, 1'b0);

      setup_basic(0, 0, 0, 0);
      program_mem();
      send_vec(1'b1, 1'b0);
      recv(5, 1'b1);

      send_vec(1'b0, 1'b0);
      check("busy_compute", int'(bz[0]), 1);
      check("ready_compute", int'(ir[0]), 0);
      w_we = 1'b1; w_addr = 4'd0; w_data = 8'd99;
      b_we = 1'b1; b_addr = 2'd0; b_data = 8'd77;
      @(negedge clk);
      w_we = 1'b0; b_we = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", int'(ov[0]), 0);
      check("midrst_in_ready", int'(ir[0]), 1);
      check("midrst_busy", int'(bz[0]), 0);
      rst_n = 1'b1;
      send_vec(1'b0, 1'b0);
      recv(0, 1'b0);

      repeat (6) begin
         for (int i = 0; i < 16; i++) wm[i] = rnd8();
         for (int i = 0; i < 4; i++) begin
            bm[i] = rnd8();
            xv[i] = rnd8();
         end
         program_mem();
         send_vec(1'b1, 1'b1);
         recv(int'($urandom_range(3)), 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
